gain_coeff_ctrl: RTL
====================

GAIN_COEFF_CTRL -- requirements
Module: gain_coeff_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
- BITWIDTH, 7, sync counter width is BITWIDTH+2.
- MARGIN, 1, headroom bits kept above the selected 16-bit window.
- HYST, 1, minimum shift change that is accepted.
- MAX_SHIFT, 32, upper clamp on the coefficient.
- COEFF_INIT, 0, coefficient value after reset.

REQ-002 Ports (name, direction, width, meaning), one per line:
- clk, in, 1, single clock.
- rst, in, 1, synchronous reset, active-high.
- frame_end, in, 1, one-cycle pulse marking the end of an integration frame.
- auto_en, in, 1, 1 = automatic coefficients, 0 = manual coefficients.
- manual_coeff_I, manual_coeff_Q, manual_coeff_U, manual_coeff_V, in, 16 each, manual coefficients.
- max_I, max_Q, max_U, max_V, in, 48 each, per-channel unsigned peak from the gain stage.
- en_sync_in, in, 1, frame sync valid.
- cnt_sync_in, in, BITWIDTH+2, point index within the frame.
- scaled_coeff_I, scaled_coeff_Q, scaled_coeff_U, scaled_coeff_V, out, 16 each, coefficients driven into the gain stage.
- coeff_update, out, 1, one-cycle pulse on the cycle the coefficients change.
- busy, out, 1, high in every state other than IDLE.
- overrun, out, 1, sticky flag: frame_end arrived while busy.
- overrun_clr, in, 1, clears overrun.

Function
REQ-003 The state machine SHALL have states IDLE, LATCH, CALC, WAIT_SYNC and APPLY.
REQ-004 IDLE: when frame_end=1, go to LATCH; otherwise stay in IDLE.
REQ-005 LATCH SHALL:
- register max_I, max_Q, max_U, max_V and auto_en;
- clear the channel index ch to 0;
- go to CALC.
REQ-006 CALC SHALL:
- process one channel per cycle, in the order I, Q, U, V;
- always take exactly 4 cycles;
- go to WAIT_SYNC after V.
REQ-007 Coefficient computation, in CALC, when auto_en was latched as 1:
- p = index of the highest set bit of the latched max;
- raw = p + 1 + MARGIN - 16, evaluated signed;
- clamp raw to the range 0..MAX_SHIFT;
- a latched max of 0 SHALL give raw = 0.
REQ-008 Hysteresis: the pending coefficient SHALL be raw if |raw - current scaled_coeff| >= HYST; otherwise it SHALL be the current value.
REQ-009 In CALC, when auto_en was latched as 0, the pending coefficient SHALL be the corresponding manual_coeff value sampled during that channel's CALC cycle.
REQ-010 WAIT_SYNC: when en_sync_in=1 and cnt_sync_in=0 in the same cycle, go to APPLY; there is no timeout.
REQ-011 APPLY SHALL:
- load all four pending coefficients into scaled_coeff_* together;
- assert coeff_update for exactly this one cycle;
- return to IDLE on the next cycle.
REQ-012 scaled_coeff_* SHALL change only in APPLY, so a frame is never processed with mixed coefficients.
REQ-013 Latency: a frame_end at cycle t SHALL give CALC at t+2..t+5. APPLY SHALL occur on the cycle after the first qualifying sync at or after t+6.
REQ-014 A frame_end while busy=1 SHALL be dropped and SHALL set overrun. A sync qualifier during LATCH or CALC SHALL be ignored.
REQ-015 overrun SHALL:
- clear on overrun_clr;
- give set priority when overrun_clr and a set event occur in the same cycle.
REQ-016 All outputs SHALL be registered.

Reset
REQ-017 On rst=1 at a clock edge, reset values SHALL be:
- state = IDLE;
- scaled_coeff_* = COEFF_INIT;
- coeff_update, busy and overrun = 0;
- pending coefficients and latched max values = 0.
REQ-018 A reset during any state SHALL discard pending coefficients, and no coeff_update SHALL follow.

Structure
REQ-019 A shared package SHALL hold:
- the state enumeration;
- the channel index constants I=0, Q=1, U=2, V=3;
- the coefficient width (16) and the max width (48).
REQ-020 A combinational sub-module lead_one_48 SHALL be used:
- it returns p (6 bits) and a zero flag;
- it is instantiated once and time-shared across the four channels in CALC.

Verification
REQ-021 Directed scenarios:
- V1: auto_en=1, max_I=0x00000000FFFF (p=15), MARGIN=1; frame_end, then sync with cnt=0 -> scaled_coeff_I=1, and coeff_update pulses once.
- V2: max_Q=2^40 -> scaled_coeff_Q=26; max_U=0 -> 0; max_V=2^48-1 -> 32 (clamped).
- V3: HYST=2, current coefficient 10, raw 11 -> stays 10; raw 13 -> becomes 13.
- V4: auto_en=0, manual_coeff_I..V = 5, 6, 7, 8 -> applied only at the sync boundary; en_sync_in with cnt_sync_in=3 -> no change.
- V5: second frame_end during WAIT_SYNC -> overrun=1 and no extra update; overrun_clr -> 0.
- V6: rst asserted in the 2nd CALC cycle -> outputs = COEFF_INIT, and no coeff_update after the later sync.

Source files
------------

// File: rtl/gain_coeff_ctrl_pkg.sv
// Shared types and widths for the gain coefficient controller.
package gain_coeff_ctrl_pkg;

    localparam int unsigned COEFF_W = 16;
    localparam int unsigned MAX_W   = 48;
    localparam int unsigned LEAD_W  = 6;
    localparam int unsigned NUM_CH  = 4;

    // Channel indices, processed in this order during CALC
    localparam logic [1:0] CH_I = 2'd0;
    localparam logic [1:0] CH_Q = 2'd1;
    localparam logic [1:0] CH_U = 2'd2;
    localparam logic [1:0] CH_V = 2'd3;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        LATCH     = 3'd1,
        CALC      = 3'd2,
        WAIT_SYNC = 3'd3,
        APPLY     = 3'd4
    } state_e;

endpackage

// File: rtl/gain_coeff_ctrl_lead_one_48.sv
// Leading-one detector for a 48-bit peak value.
module lead_one_48
    import gain_coeff_ctrl_pkg::*;
(
    input  logic [MAX_W-1:0]  value,
    output logic [LEAD_W-1:0] pos,
    output logic              zero
);

    // Scan upward so the highest set bit wins
    always_comb begin
        pos  = '0;
        zero = (value == '0);
        for (int unsigned i = 0; i < MAX_W; i++) begin
            if (value[i]) begin
                pos = LEAD_W'(i);
            end
        end
    end

endmodule

// File: rtl/gain_coeff_ctrl.sv
// Per-frame gain coefficient controller: computes shift coefficients from
// channel peaks (or takes manual values) and applies them on a frame sync.
module gain_coeff_ctrl
    import gain_coeff_ctrl_pkg::*;
#(
    parameter int unsigned BITWIDTH   = 7,
    parameter int unsigned MARGIN     = 1,
    parameter int unsigned HYST       = 1,
    parameter int unsigned MAX_SHIFT  = 32,
    parameter int unsigned COEFF_INIT = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 frame_end,
    input  logic                 auto_en,
    input  logic [COEFF_W-1:0]   manual_coeff_I,
    input  logic [COEFF_W-1:0]   manual_coeff_Q,
    input  logic [COEFF_W-1:0]   manual_coeff_U,
    input  logic [COEFF_W-1:0]   manual_coeff_V,
    input  logic [MAX_W-1:0]     max_I,
    input  logic [MAX_W-1:0]     max_Q,
    input  logic [MAX_W-1:0]     max_U,
    input  logic [MAX_W-1:0]     max_V,
    input  logic                 en_sync_in,
    input  logic [BITWIDTH+1:0]  cnt_sync_in,
    output logic [COEFF_W-1:0]   scaled_coeff_I,
    output logic [COEFF_W-1:0]   scaled_coeff_Q,
    output logic [COEFF_W-1:0]   scaled_coeff_U,
    output logic [COEFF_W-1:0]   scaled_coeff_V,
    output logic                 coeff_update,
    output logic                 busy,
    output logic                 overrun,
    input  logic                 overrun_clr
);

    state_e               state_q, state_d;
    logic [1:0]           ch_q;
    logic                 auto_q;
    logic [MAX_W-1:0]     max_q   [NUM_CH];
    logic [COEFF_W-1:0]   pend_q  [NUM_CH];
    logic [COEFF_W-1:0]   coeff_q [NUM_CH];
    logic [COEFF_W-1:0]   man     [NUM_CH];

    logic [MAX_W-1:0]     sel_max;
    logic [LEAD_W-1:0]    lead_pos;
    logic                 lead_zero;
    logic [COEFF_W-1:0]   pend_c;
    logic                 sync_zero;
    int                   raw_shift;
    int                   shift_diff;

    assign man[CH_I] = manual_coeff_I;
    assign man[CH_Q] = manual_coeff_Q;
    assign man[CH_U] = manual_coeff_U;
    assign man[CH_V] = manual_coeff_V;

    assign scaled_coeff_I = coeff_q[CH_I];
    assign scaled_coeff_Q = coeff_q[CH_Q];
    assign scaled_coeff_U = coeff_q[CH_U];
    assign scaled_coeff_V = coeff_q[CH_V];

    assign sync_zero = en_sync_in && (cnt_sync_in == '0);
    assign sel_max   = max_q[ch_q];

    // One detector shared by all channels, one channel per CALC cycle
    lead_one_48 u_lead (
        .value (sel_max),
        .pos   (lead_pos),
        .zero  (lead_zero)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:      if (frame_end) state_d = LATCH;
            LATCH:     state_d = CALC;
            CALC:      if (ch_q == CH_V) state_d = WAIT_SYNC;
            WAIT_SYNC: if (sync_zero) state_d = APPLY;
            APPLY:     state_d = IDLE;
            default:   state_d = IDLE;
        endcase
    end

    // Clamped shift with hysteresis against the coefficient currently in use
    always_comb begin
        if (lead_zero) begin
            raw_shift = 0;
        end else begin
            raw_shift = int'(lead_pos) + 1 + int'(MARGIN) - int'(COEFF_W);
        end
        if (raw_shift < 0) begin
            raw_shift = 0;
        end else if (raw_shift > int'(MAX_SHIFT)) begin
            raw_shift = int'(MAX_SHIFT);
        end
        shift_diff = raw_shift - int'(coeff_q[ch_q]);
        if (shift_diff < 0) begin
            shift_diff = -shift_diff;
        end
        if (!auto_q) begin
            pend_c = man[ch_q];
        end else if (shift_diff >= int'(HYST)) begin
            pend_c = COEFF_W'(raw_shift);
        end else begin
            pend_c = coeff_q[ch_q];
        end
    end

    // Latch, per-channel pending values, and the atomic coefficient load
    always_ff @(posedge clk) begin
        if (rst) begin
            auto_q       <= 1'b0;
            ch_q         <= CH_I;
            max_q        <= '{default: '0};
            pend_q       <= '{default: '0};
            coeff_q      <= '{default: COEFF_W'(COEFF_INIT)};
            coeff_update <= 1'b0;
            busy         <= 1'b0;
        end else begin
            coeff_update <= (state_d == APPLY);
            busy         <= (state_d != IDLE);
            case (state_q)
                LATCH: begin
                    max_q[CH_I] <= max_I;
                    max_q[CH_Q] <= max_Q;
                    max_q[CH_U] <= max_U;
                    max_q[CH_V] <= max_V;
                    auto_q      <= auto_en;
                    ch_q        <= CH_I;
                end
                CALC: begin
                    pend_q[ch_q] <= pend_c;
                    ch_q         <= ch_q + 2'd1;
                end
                default: ;
            endcase
            if (state_d == APPLY) begin
                coeff_q <= pend_q;
            end
        end
    end

    // Sticky overrun; a dropped frame_end beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (frame_end && busy) begin
            overrun <= 1'b1;
        end else if (overrun_clr) begin
            overrun <= 1'b0;
        end
    end

endmodule
